// File: rtl/subtractor32_seq.sv
// subtractor32_seq: computes a - b (32 bit) one nibble per clock, with borrow and compare flags.
// Ports:
//   clk       - clock; all state changes on its rising edge
//   reset_n   - asynchronous active-low reset
//   in_valid  - an operand pair is offered on a/b
//   in_ready  - high only in IDLE and out of reset; operands are accepted on in_valid && in_ready
//   a, b      - minuend and subtrahend, sampled only at the input handshake
//   out_valid - diff and the flags are valid; held until an edge with out_ready high
//   out_ready - the consumer takes the result
//   diff      - a - b modulo 2^32
//   borrow    - 1 iff a < b unsigned
//   ltu       - unsigned less-than, same as borrow
//   lt        - signed (two's complement) a < b
//   zero      - diff == 0
module subtractor32_seq (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] diff,
   output logic        borrow,
   output logic        ltu,
   output logic        lt,
   output logic        zero
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   logic [1:0]  state;
   logic [2:0]  cnt;
   logic        carry;
   logic [31:0] a_sh;
   logic [31:0] nb_sh;
   logic [31:0] acc;
   logic        a_sign;
   logic        b_sign;
   logic [4:0]  sum;
   logic [31:0] diff_next;
   // a and ~b shift right one nibble per cycle, so the adder always sees nibble 0;
   // result nibbles enter acc from the top and land in place after eight shifts
   assign sum       = {1'b0, a_sh[3:0]} + {1'b0, nb_sh[3:0]} + {4'd0, carry};
   assign diff_next = {sum[3:0], acc[31:4]};
   assign in_ready  = reset_n && state == IDLE;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         carry     <= 1'b0;
         a_sh      <= '0;
         nb_sh     <= '0;
         acc       <= '0;
         a_sign    <= 1'b0;
         b_sign    <= 1'b0;
         out_valid <= 1'b0;
         diff      <= '0;
         borrow    <= 1'b0;
         ltu       <= 1'b0;
         lt        <= 1'b0;
         zero      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_sh   <= a;
               nb_sh  <= ~b;
               a_sign <= a[31];
               b_sign <= b[31];
               carry  <= 1'b1;
               cnt    <= '0;
               state  <= CALC;
            end
            CALC: begin
               a_sh  <= a_sh >> 4;
               nb_sh <= nb_sh >> 4;
               acc   <= diff_next;
               carry <= sum[4];
               cnt   <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  diff      <= diff_next;
                  borrow    <= ~sum[4];
                  ltu       <= ~sum[4];
                  // differing signs decide by a's sign alone; equal signs cannot overflow
                  lt        <= (a_sign != b_sign) ? a_sign : diff_next[31];
                  zero      <= diff_next == '0;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
